serial_port_router: RTL and testbench
=====================================

// Module: serial_port_router
// PURPOSE
//  N-way serial port router with glitch-free switching between physical ports (console UART, USER_IO, ...).
//  Sits between the selected CPU core's UART (txd/rts/rxd/cts) and the physical pins, in the clk_sys domain.
//  Generates the 16x baud increment/tick for the cores and drains the line before any port or baud change.
//  Holds RTS/CTS in "stop" during each change, so no partial frames or spurious flow edges reach either side.
// PARAMETERS
//  NUM_PORTS        2         physical ports (>=2); port 0 = console UART
//  HOLDOFF_CYCLES   50000     post-switch settle time, clk_sys cycles (1 ms @ 50 MHz)
//  IDLE_BITS        12        line-idle bit-times required before a switch completes
//  DRAIN_MAX_CYCLES 5000000   DRAIN timeout, clk_sys cycles (100 ms)
//  SYNC_STAGES      2         synchroniser depth on port_rxd/port_cts
// PORTS
//  clk_sys        in   1          system clock
//  reset          in   1          synchronous, active-high
//  port_sel       in   PW         requested port; PW=$clog2(NUM_PORTS); values >= NUM_PORTS are ignored (current port kept)
//  baud_sel       in   3          0..5 = 115200,38400,19200,9600,4800,2400; 6,7 -> 115200
//  flow_en        in   1          1 = RTS/CTS active
//  core_txd       in   1          TX from core
//  core_rts       in   1          RTS from core, active low
//  core_rxd       out  1          RX to core
//  core_cts       out  1          CTS to core, active low (0 = clear to send)
//  baud_increment out  16         accumulator step for the cores' 16x clocks
//  baud_tick      out  1          1-cycle pulse at 16x baud
//  port_rxd       in   NUM_PORTS  RX pins
//  port_cts       in   NUM_PORTS  CTS pins, active low
//  port_txd       out  NUM_PORTS  TX pins
//  port_rts       out  NUM_PORTS  RTS pins
//  port_rx_en     out  NUM_PORTS  open-drain release for RX pin (1 = input)
//  port_cts_en    out  NUM_PORTS  open-drain release for CTS pin
//  active_port    out  PW         port currently connected
//  switching      out  1          1 while in DRAIN or HOLDOFF
//  break_det      out  1          see CONFIGURATION
// BEHAVIOUR
//  Baud increments: 2416, 805, 403, 201, 101, 50. Registered, 1-cycle latency from baud_sel.
//  Accumulator: 16-bit acc += baud_increment; baud_tick = carry out of bit 15.
//  baud_increment and the accumulator update only when entering HOLDOFF; the accumulator clears to 0 at that point.
//  States:
//   ACTIVE  -> DRAIN    on (synced port_sel != active_port) or (baud_sel != latched baud_sel)
//   DRAIN   -> HOLDOFF  when idle_cnt reaches IDLE_BITS*16 ticks, or drain_cnt == DRAIN_MAX_CYCLES
//   HOLDOFF -> ACTIVE   when hold_cnt == HOLDOFF_CYCLES-1; on entry, latch active_port = port_sel and latch baud_sel
//  idle_cnt resets to 0 on any baud_tick with core_txd==0 or active synced rxd==0.
//  A request changing again during DRAIN or HOLDOFF is picked up on return to ACTIVE; it never aborts a sequence.
//  Reset: state = HOLDOFF; active_port = 0; baud = 115200; all counters = 0.
//   Outputs during reset: port_txd = all 1; port_rts = all 1; core_rxd = 1; core_cts = flow_en; switching = 1;
//   break_det = 0; port_rx_en[0] = 1, other bits 0; port_cts_en = 0.
//  Routing (k = active_port; s = synced pins):
//   core_rxd      = ACTIVE ? s_rxd[k] : 1
//   port_txd[k]   = core_txd in ACTIVE/DRAIN (current frame may finish), 1 in HOLDOFF
//   port_txd[j!=k] = 1
//   port_rts[k]   = (flow_en & ACTIVE) ? core_rts : 1;  port_rts[j!=k] = 1
//   core_cts      = !flow_en ? 0 : (ACTIVE ? s_cts[k] : 1)
//   port_rx_en    = onehot(k)
//   port_cts_en   = flow_en ? onehot(k) : 0
//  flow_en is read combinationally; toggling it mid-frame takes effect next cycle, with no state change.
//  Reset asserted in any state: returns to the reset state on the next edge.
// CONFIGURATION
//  SERIAL_ROUTER_BREAK_DETECT_EN defined:
//   break_det pulses 1 cycle when s_rxd[k] has stayed low for IDLE_BITS*16 consecutive ticks in ACTIVE.
//   It re-arms after rxd goes high.
//  Not defined: break_det tied 0, and no break counter is built.
// STRUCTURE
//  Package serial_router_pkg holds:
//   - router_state_e {ACTIVE, DRAIN, HOLDOFF}
//   - baud_rate_e (3-bit, values as baud_sel)
//   - function baud_inc(baud_rate_e) -> [15:0]
//   - localparam TICKS_PER_BIT = 16
//  Sub-module serial_baud_gen: accumulator plus increment register; ports clk_sys, reset, load, baud_sel -> baud_increment, baud_tick.
// TESTING
//  T1 reset:
//   Hold reset 5 cycles, then release with port_sel=0 and flow_en=1.
//   switching=1 and core_cts=1 for 50000 cycles, then switching=0, core_cts=s_cts[0], baud_increment=2416.
//  T2 switch:
//   In ACTIVE, set port_sel=1 while core_txd is sending 0x55.
//   port_txd[0] completes the frame, then waits 12 bit-times idle, then HOLDOFF.
//   active_port=1, port_rx_en=2'b10, and port_txd[1] stays 1 until ACTIVE.
//  T3 drain timeout:
//   Hold core_txd=0, then request a switch.
//   HOLDOFF is entered exactly at DRAIN_MAX_CYCLES.
//  T4 baud change:
//   Set baud_sel=3 in ACTIVE.
//   After the DRAIN/HOLDOFF sequence, baud_increment=201 and baud_tick period is 326 or 327 cycles.
//   baud_sel=7 gives 2416.
//  T5 flow:
//   With flow_en=0: core_cts=0 and all port_rts=1 regardless of pins.
//   With flow_en=1 in ACTIVE: core_rts=0 gives port_rts[k]=0, and port_cts[k]=1 gives core_cts=1 after SYNC_STAGES+1 cycles.
//  T6 break (macro on):
//   Drive port_rxd[k]=0 for 12 bit-times -> exactly one break_det pulse.
//   Rxd high then low again -> a second pulse.
//   Macro off: break_det is never 1.

Source files
------------

// File: rtl/serial_port_router_pkg.sv
// Shared types and helpers for the serial port router: FSM states, baud
// selector encoding and the baud-select to accumulator-step mapping.
package serial_router_pkg;

    localparam int TICKS_PER_BIT = 16;

    typedef enum logic [1:0] {
        ACTIVE  = 2'd0,
        DRAIN   = 2'd1,
        HOLDOFF = 2'd2
    } router_state_e;

    typedef enum logic [2:0] {
        BAUD_115200 = 3'd0,
        BAUD_38400  = 3'd1,
        BAUD_19200  = 3'd2,
        BAUD_9600   = 3'd3,
        BAUD_4800   = 3'd4,
        BAUD_2400   = 3'd5,
        BAUD_RSV6   = 3'd6,
        BAUD_RSV7   = 3'd7
    } baud_rate_e;

    // Step added to the 16-bit phase accumulator each clk_sys cycle (50 MHz)
    // so that its carry-out fires at 16x the baud rate. Reserved codes
    // fall back to 115200.
    function automatic logic [15:0] baud_inc(baud_rate_e rate);
        case (rate)
            BAUD_38400: return 16'd805;
            BAUD_19200: return 16'd403;
            BAUD_9600:  return 16'd201;
            BAUD_4800:  return 16'd101;
            BAUD_2400:  return 16'd50;
            default:    return 16'd2416;
        endcase
    endfunction

endpackage

// File: rtl/serial_port_router_if.sv
// UART signal bundle between the CPU core side and the physical pins.
// The router takes the slave view; the environment driving core and pins
// takes the master view.
interface serial_port_router_if #(
    parameter int NUM_PORTS = 2
);
    logic                 core_txd;
    logic                 core_rts;
    logic                 core_rxd;
    logic                 core_cts;
    logic [NUM_PORTS-1:0] port_rxd;
    logic [NUM_PORTS-1:0] port_cts;
    logic [NUM_PORTS-1:0] port_txd;
    logic [NUM_PORTS-1:0] port_rts;
    logic [NUM_PORTS-1:0] port_rx_en;
    logic [NUM_PORTS-1:0] port_cts_en;

    modport master (
        output core_txd, core_rts, port_rxd, port_cts,
        input  core_rxd, core_cts, port_txd, port_rts, port_rx_en, port_cts_en
    );

    modport slave (
        input  core_txd, core_rts, port_rxd, port_cts,
        output core_rxd, core_cts, port_txd, port_rts, port_rx_en, port_cts_en
    );
endinterface

// File: rtl/serial_port_router_baud_gen.sv
// 16x baud generator: phase accumulator whose carry-out is the tick.
// The step and the phase only change on load, so a new rate starts from a
// clean phase while the line is held idle.
module serial_baud_gen
    import serial_router_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        load,
    input  logic [2:0]  baud_sel,
    output logic [15:0] baud_increment,
    output logic        baud_tick
);

    logic [15:0] acc;
    logic [16:0] sum;

    assign sum = {1'b0, acc} + {1'b0, baud_increment};

    // Accumulate every cycle; reload step and clear phase on load.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            baud_increment <= baud_inc(BAUD_115200);
            acc            <= '0;
            baud_tick      <= 1'b0;
        end else if (load) begin
            baud_increment <= baud_inc(baud_rate_e'(baud_sel));
            acc            <= '0;
            baud_tick      <= 1'b0;
        end else begin
            acc       <= sum[15:0];
            baud_tick <= sum[16];
        end
    end

endmodule

// File: rtl/serial_port_router.sv
// N-way serial port router. Connects the core UART to one physical port,
// drains the line and holds flow control in "stop" around every port or
// baud change. Optional break detector: SERIAL_ROUTER_BREAK_DETECT_EN.
module serial_port_router
    import serial_router_pkg::*;
#(
    parameter int  NUM_PORTS        = 2,
    parameter int  HOLDOFF_CYCLES   = 50000,
    parameter int  IDLE_BITS        = 12,
    parameter int  DRAIN_MAX_CYCLES = 5000000,
    parameter int  SYNC_STAGES      = 2,
    localparam int PW               = $clog2(NUM_PORTS)
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic [PW-1:0] port_sel,
    input  logic [2:0]    baud_sel,
    input  logic          flow_en,
    serial_port_router_if.slave bus,
    output logic [15:0]   baud_increment,
    output logic          baud_tick,
    output logic [PW-1:0] active_port,
    output logic          switching,
    output logic          break_det
);

    localparam int IDLE_TICKS = IDLE_BITS * TICKS_PER_BIT;
    localparam int IW = $clog2(IDLE_TICKS + 1);
    localparam int DW = $clog2(DRAIN_MAX_CYCLES + 1);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

    router_state_e        state, state_next;
    logic [NUM_PORTS-1:0] rxd_sync [SYNC_STAGES];
    logic [NUM_PORTS-1:0] cts_sync [SYNC_STAGES];
    logic [PW-1:0]        sel_sync [SYNC_STAGES];
    logic [NUM_PORTS-1:0] s_rxd, s_cts, onehot, txd_map, rts_map;
    logic [PW-1:0]        sel_s;
    logic [2:0]           baud_latched;
    logic [IW-1:0]        idle_cnt;
    logic [DW-1:0]        drain_cnt;
    logic [HW-1:0]        hold_cnt;
    logic                 sel_ok, req_change, load, s_rxd_k, s_cts_k;

    // Pin and request synchronisers; pins come up in the idle/stop level.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rxd_sync[i] <= '1;
                cts_sync[i] <= '1;
                sel_sync[i] <= '0;
            end
        end else begin
            rxd_sync[0] <= bus.port_rxd;
            cts_sync[0] <= bus.port_cts;
            sel_sync[0] <= port_sel;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rxd_sync[i] <= rxd_sync[i-1];
                cts_sync[i] <= cts_sync[i-1];
                sel_sync[i] <= sel_sync[i-1];
            end
        end
    end

    assign s_rxd      = rxd_sync[SYNC_STAGES-1];
    assign s_cts      = cts_sync[SYNC_STAGES-1];
    assign sel_s      = sel_sync[SYNC_STAGES-1];
    assign s_rxd_k    = s_rxd[active_port];
    assign s_cts_k    = s_cts[active_port];
    assign sel_ok     = int'(sel_s) < NUM_PORTS;
    assign req_change = (sel_ok && (sel_s != active_port)) || (baud_sel != baud_latched);
    assign load       = (state == DRAIN) && (state_next == HOLDOFF);

    // State register; reset parks in HOLDOFF so the pins settle first.
    always_ff @(posedge clk_sys) begin
        if (reset) state <= HOLDOFF;
        else       state <= state_next;
    end

    // Next-state logic: a new request is only sampled in ACTIVE.
    always_comb begin
        state_next = state;
        case (state)
            ACTIVE:  if (req_change) state_next = DRAIN;
            DRAIN:   if ((idle_cnt == IW'(IDLE_TICKS)) ||
                         (drain_cnt == DW'(DRAIN_MAX_CYCLES))) state_next = HOLDOFF;
            HOLDOFF: if (hold_cnt == HW'(HOLDOFF_CYCLES - 1)) state_next = ACTIVE;
            default: state_next = HOLDOFF;
        endcase
    end

    // Drain/holdoff counters and the port/baud latch taken on HOLDOFF entry.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            active_port  <= '0;
            baud_latched <= 3'd0;
            idle_cnt     <= '0;
            drain_cnt    <= '0;
            hold_cnt     <= '0;
        end else begin
            drain_cnt <= (state == DRAIN)   ? drain_cnt + 1'b1 : '0;
            hold_cnt  <= (state == HOLDOFF) ? hold_cnt + 1'b1  : '0;
            if (state != DRAIN)
                idle_cnt <= '0;
            else if (baud_tick)
                idle_cnt <= (!bus.core_txd || !s_rxd_k) ? '0 : idle_cnt + 1'b1;
            if (load) begin
                if (sel_ok) active_port <= sel_s;
                baud_latched <= baud_sel;
            end
        end
    end

    serial_baud_gen u_baud_gen (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .load          (load),
        .baud_sel      (baud_sel),
        .baud_increment(baud_increment),
        .baud_tick     (baud_tick)
    );

    // Pin routing: TX may finish its frame during DRAIN; flow stays "stop"
    // outside ACTIVE; the CTS release is also withheld while in reset.
    always_comb begin
        onehot  = NUM_PORTS'(1) << active_port;
        txd_map = '1;
        rts_map = '1;
        if (state != HOLDOFF) txd_map[active_port] = bus.core_txd;
        if (flow_en && (state == ACTIVE)) rts_map[active_port] = bus.core_rts;
    end

    assign bus.port_txd    = txd_map;
    assign bus.port_rts    = rts_map;
    assign bus.port_rx_en  = onehot;
    assign bus.port_cts_en = (flow_en && !reset) ? onehot : '0;
    assign bus.core_rxd    = (state == ACTIVE) ? s_rxd_k : 1'b1;
    assign bus.core_cts    = !flow_en ? 1'b0 : ((state == ACTIVE) ? s_cts_k : 1'b1);
    assign switching       = (state != ACTIVE);

`ifdef SERIAL_ROUTER_BREAK_DETECT_EN
    logic [IW-1:0] brk_cnt;

    // Break detector: one pulse per low stretch, re-armed when rxd goes high.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            brk_cnt   <= '0;
            break_det <= 1'b0;
        end else begin
            break_det <= 1'b0;
            if ((state != ACTIVE) || s_rxd_k) begin
                brk_cnt <= '0;
            end else if (baud_tick && (brk_cnt != IW'(IDLE_TICKS))) begin
                brk_cnt <= brk_cnt + 1'b1;
                if (brk_cnt == IW'(IDLE_TICKS - 1)) break_det <= 1'b1;
            end
        end
    end
`else
    assign break_det = 1'b0;
`endif

endmodule

// File: tb/tb_serial_port_router.sv
// Self-checking bench for serial_port_router with a small expected-value
// queue. Build with or without SERIAL_ROUTER_BREAK_DETECT_EN.
module tb_serial_port_router;

    localparam int NP    = 2;
    localparam int HOLD  = 200;
    localparam int IBITS = 12;
    localparam int DMAX  = 12000;
    localparam int SYNC  = 2;
    localparam int BIT   = 434;   // clk_sys cycles per bit at 115200 (16 ticks of 27.13)
`ifdef SERIAL_ROUTER_BREAK_DETECT_EN
    localparam int BRK_EXP = 1;
`else
    localparam int BRK_EXP = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [0:0]  port_sel;
    logic [2:0]  baud_sel;
    logic        flow_en;
    logic [15:0] baud_increment;
    logic        baud_tick;
    logic [0:0]  active_port;
    logic        switching;
    logic        break_det;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        string tag;
        int    val;
    } exp_t;
    exp_t sb_q[$];

    serial_port_router_if #(.NUM_PORTS(NP)) bus ();

    serial_port_router #(
        .NUM_PORTS(NP), .HOLDOFF_CYCLES(HOLD), .IDLE_BITS(IBITS),
        .DRAIN_MAX_CYCLES(DMAX), .SYNC_STAGES(SYNC)
    ) dut (
        .clk_sys(clk), .reset(reset), .port_sel(port_sel), .baud_sel(baud_sel),
        .flow_en(flow_en), .bus(bus), .baud_increment(baud_increment),
        .baud_tick(baud_tick), .active_port(active_port), .switching(switching),
        .break_det(break_det)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input int obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", obs, -1);
        end else begin
            e = sb_q.pop_front();
            check_val(e.tag, obs, e.val);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_sw(input logic val, input int max, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < max) begin
            @(negedge clk);
            n++;
            if (switching === val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_port(input logic [0:0] val, input int max, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < max) begin
            @(negedge clk);
            n++;
            if (active_port === val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_breaks(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(negedge clk);
            if (break_det === 1'b1) pulses++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.core_txd = frame[i];
            cycles(BIT);
        end
    endtask

    initial begin
        int  n, p, m, t0, t1;
        bit  ok;

        // T1: reset outputs, holdoff length, first ACTIVE state
        reset = 1'b1; port_sel = 1'b0; baud_sel = 3'd0; flow_en = 1'b1;
        bus.core_txd = 1'b1; bus.core_rts = 1'b1;
        bus.port_rxd = 2'b11; bus.port_cts = 2'b00;
        cycles(5);
        check_val("rst_switching", switching, 1);
        check_val("rst_port_txd", bus.port_txd, 3);
        check_val("rst_port_rts", bus.port_rts, 3);
        check_val("rst_core_rxd", bus.core_rxd, 1);
        check_val("rst_core_cts", bus.core_cts, 1);
        check_val("rst_break", break_det, 0);
        check_val("rst_rx_en", bus.port_rx_en, 1);
        check_val("rst_cts_en", bus.port_cts_en, 0);
        check_val("rst_active", active_port, 0);
        reset = 1'b0;
        sb_push("t1_holdoff_len", HOLD);
        sb_push("t1_incr", 2416);
        sb_push("t1_core_cts", 0);
        n = 0;
        while (n < HOLD + 50) begin
            @(negedge clk);
            n++;
            if (n == HOLD / 2) check_val("t1_cts_in_holdoff", bus.core_cts, 1);
            if (switching === 1'b0) break;
        end
        sb_pop(n);
        sb_pop(baud_increment);
        sb_pop(bus.core_cts);

        // T5: flow control
        flow_en = 1'b0; bus.port_cts = 2'b11; bus.core_rts = 1'b0;
        cycles(4);
        check_val("t5_cts_noflow", bus.core_cts, 0);
        check_val("t5_rts_noflow", bus.port_rts, 3);
        check_val("t5_ctsen_noflow", bus.port_cts_en, 0);
        flow_en = 1'b1; bus.port_cts = 2'b00;
        cycles(4);
        check_val("t5_rts_flow", bus.port_rts, 2);
        check_val("t5_ctsen_flow", bus.port_cts_en, 1);
        check_val("t5_cts_clear", bus.core_cts, 0);
        bus.port_cts = 2'b01;
        cycles(1);
        check_val("t5_cts_sync_early", bus.core_cts, 0);
        cycles(SYNC);
        check_val("t5_cts_stop", bus.core_cts, 1);
        bus.port_cts = 2'b00; bus.core_rts = 1'b1;
        cycles(4);

        // T6: break detection on port 0
        bus.port_rxd = 2'b10;
        cycles(4);
        check_val("t6_core_rxd_low", bus.core_rxd, 0);
        count_breaks(5600, p);
        check_val("t6_break_first", p, BRK_EXP);
        bus.port_rxd = 2'b11;
        count_breaks(300, p);
        check_val("t6_break_idle", p, 0);
        bus.port_rxd = 2'b10;
        count_breaks(5600, p);
        check_val("t6_break_second", p, BRK_EXP);
        bus.port_rxd = 2'b11;
        cycles(50);
        check_val("t6_no_switch", switching, 0);

        // T2: switch to port 1 while a 0x55 frame is in flight on port 0
        t0 = cyc;
        fork
            send_byte(8'h55);
        join_none
        cycles(BIT + 200);
        port_sel = 1'b1;
        sb_push("t2_active_port", 1);
        sb_push("t2_rx_en", 2);
        sb_push("t2_txd_holdoff", 3);
        cycles(SYNC + 2);
        check_val("t2_switching", switching, 1);
        cycles(BIT / 2);
        check_val("t2_txd0_bit1", bus.port_txd, 3);
        cycles(BIT);
        check_val("t2_txd0_bit2", bus.port_txd, 2);
        wait_port(1'b1, DMAX, n, ok);
        check_val("t2_port_wait", ok, 1);
        t1 = cyc;
        sb_pop(active_port);
        sb_pop(bus.port_rx_en);
        sb_pop(bus.port_txd);
        m = t1 - (t0 + 9 * BIT);
        check_val("t2_idle_window", (m >= 5150 && m <= 5270), 1);
        bus.core_txd = 1'b0;
        cycles(5);
        check_val("t2_txd1_holdoff", bus.port_txd, 3);
        bus.core_txd = 1'b1;
        wait_sw(1'b0, HOLD + 20, n, ok);
        check_val("t2_back_active", ok, 1);
        check_val("t2_cts_en", bus.port_cts_en, 2);
        bus.core_txd = 1'b0;
        cycles(1);
        check_val("t2_txd1_active", bus.port_txd, 1);
        bus.core_txd = 1'b1;
        bus.port_rxd = 2'b01;
        cycles(4);
        check_val("t2_core_rxd_p1", bus.core_rxd, 0);
        bus.port_rxd = 2'b11;
        cycles(4);

        // T3: drain timeout with core_txd stuck low; counter runs 0..DMAX
        bus.core_txd = 1'b0;
        port_sel = 1'b0;
        sb_push("t3_drain_len", DMAX + 1);
        wait_sw(1'b1, 20, n, ok);
        check_val("t3_drain_start", ok, 1);
        wait_port(1'b0, DMAX + 50, n, ok);
        sb_pop(n);
        bus.core_txd = 1'b1;
        wait_sw(1'b0, HOLD + 20, n, ok);
        check_val("t3_back_active", ok, 1);

        // T4: baud changes (reserved code first, then 9600)
        baud_sel = 3'd7;
        sb_push("t4_incr_code7", 2416);
        wait_sw(1'b1, 5, n, ok);
        check_val("t4_code7_drain", ok, 1);
        wait_sw(1'b0, DMAX + HOLD, n, ok);
        check_val("t4_code7_done", ok, 1);
        sb_pop(baud_increment);
        baud_sel = 3'd3;
        sb_push("t4_incr_9600", 201);
        wait_sw(1'b1, 5, n, ok);
        check_val("t4_9600_drain", ok, 1);
        check_val("t4_incr_held", baud_increment, 2416);
        wait_sw(1'b0, DMAX + HOLD, n, ok);
        check_val("t4_9600_done", ok, 1);
        sb_pop(baud_increment);
        n = 0;
        while (n < 400 && baud_tick !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 2; k++) begin
            p = 0;
            do begin
                @(negedge clk);
                p++;
            end while (p < 400 && baud_tick !== 1'b1);
            check_val("t4_tick_period", (p == 326 || p == 327), 1);
        end

        check_val("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
